// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game controller: start/countdown/play/done sequencing,
// pseudo-random mole placement, whack scoring and best-score tracking.
module whack_game_ctrl #(
    parameter int          NUM_MOLES   = 16,
    parameter int          COUNTDOWN_S = 3,
    parameter int          GAME_S      = 30,
    parameter int          SCORE_W     = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    input  logic                 tick_1hz_i,
    input  logic                 tick_10hz_i,
    input  logic [NUM_MOLES-1:0] switches_i,
    output logic [NUM_MOLES-1:0] moles_o,
    output logic [1:0]           state_o,
    output logic [7:0]           time_o,
    output logic [SCORE_W-1:0]   score_o,
    output logic [SCORE_W-1:0]   hi_score_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_COUNTDOWN = 2'b01,
        ST_PLAY      = 2'b10,
        ST_DONE      = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [7:0]           time_q, time_d;
    logic [SCORE_W-1:0]   score_q, score_d, score_play;
    logic [SCORE_W-1:0]   hi_q, hi_d;
    logic [3:0]           rate_q, rate_d, period;
    logic [3:0]           lit_idx, cand_idx, new_idx;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [NUM_MOLES-1:0] sw_prev_q, moles_q, moles_d, whack;
    logic                 hit, miss;

    // Galois LFSR for x^16+x^14+x^13+x^11+1, free-running in every state
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & 16'hB400);
    end

    // A whack is any switch edge; one hit wins over any number of misses
    always_comb begin
        whack = switches_i ^ sw_prev_q;
        hit   = |(whack & moles_q);
        miss  = (|whack) & ~hit;
    end

    // Mole relight cadence in 10 Hz ticks for the difficulty latched at start
    always_comb begin
        case (mode_q)
            2'd1:    period = 4'd10;
            2'd2:    period = 4'd5;
            2'd3:    period = 4'd2;
            default: period = 4'd10;
        endcase
    end

    // Pick the next mole from the LFSR, stepping past the currently lit one
    always_comb begin
        lit_idx = 4'd0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            if (moles_q[i]) begin
                lit_idx = 4'(i);
            end
        end
        cand_idx = 4'(int'(lfsr_q[3:0]) % NUM_MOLES);
        new_idx  = cand_idx;
        if ((|moles_q) && (cand_idx == lit_idx)) begin
            new_idx = (cand_idx == 4'(NUM_MOLES - 1)) ? 4'd0 : cand_idx + 4'd1;
        end
    end

    // Saturating score after this cycle's whack outcome
    always_comb begin
        score_play = score_q;
        if (hit && (score_q != {SCORE_W{1'b1}})) begin
            score_play = score_q + 1'b1;
        end else if (miss && (score_q != '0)) begin
            score_play = score_q - 1'b1;
        end
    end

    // Next-state and datapath updates for the game sequence
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        time_d  = time_q;
        score_d = score_q;
        hi_d    = hi_q;
        rate_d  = rate_q;
        moles_d = moles_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i && (mode_i != 2'd0)) begin
                    mode_d  = mode_i;
                    time_d  = 8'(COUNTDOWN_S);
                    state_d = ST_COUNTDOWN;
                end
            end
            ST_COUNTDOWN: begin
                if (tick_1hz_i) begin
                    if (time_q == 8'd1) begin
                        state_d = ST_PLAY;
                        time_d  = 8'(GAME_S);
                        score_d = '0;
                        rate_d  = 4'd0;
                        moles_d = '0;
                    end else begin
                        time_d = time_q - 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                score_d = score_play;
                if (hit) begin
                    moles_d = '0;
                end
                if (tick_10hz_i) begin
                    if ((rate_q + 4'd1) == period) begin
                        rate_d  = 4'd0;
                        moles_d = {{(NUM_MOLES-1){1'b0}}, 1'b1} << new_idx;
                    end else begin
                        rate_d = rate_q + 4'd1;
                    end
                end
                if (tick_1hz_i) begin
                    if (time_q == 8'd1) begin
                        state_d = ST_DONE;
                        time_d  = 8'd0;
                        moles_d = '0;
                        if (score_play > hi_q) begin
                            hi_d = score_play;
                        end
                    end else begin
                        time_d = time_q - 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset overriding every other input
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            mode_q    <= 2'd0;
            time_q    <= 8'd0;
            score_q   <= '0;
            hi_q      <= '0;
            rate_q    <= 4'd0;
            moles_q   <= '0;
            lfsr_q    <= LFSR_SEED;
            sw_prev_q <= switches_i;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            time_q    <= time_d;
            score_q   <= score_d;
            hi_q      <= hi_d;
            rate_q    <= rate_d;
            moles_q   <= moles_d;
            lfsr_q    <= lfsr_d;
            sw_prev_q <= switches_i;
        end
    end

    assign moles_o    = moles_q;
    assign state_o    = state_q;
    assign time_o     = time_q;
    assign score_o    = score_q;
    assign hi_score_o = hi_q;

endmodule
